alu_operand_ctrl: RTL and testbench

- Moore/Mealy sequencer for the multicycle datapath. It is the driving end of the ALU operand-select interface.
- Each cycle it generates the ALU source-A select, source-B select and ALU operation.
- It also generates the PC, IR, memory and register-file strobes needed to walk one instruction through fetch, decode, execute, memory and writeback.
- Subset: R-type add/sub/and, addi, beq, bne, lw, sw, j.

---
 rtl/alu_operand_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_operand_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_ctrl.sv
// Multicycle datapath sequencer: walks one instruction through
// fetch, decode, execute, memory and writeback. It drives the ALU
// operand selects and the PC, IR, memory and register-file strobes.
module alu_operand_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alu_srcA,
  output logic [2:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       aluout_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_R     = 4'd3,
    S_WB_R       = 4'd4,
    S_EXEC_ADDI  = 4'd5,
    S_WB_I       = 4'd6,
    S_EXEC_BR    = 4'd7,
    S_ADDR       = 4'd8,
    S_MEM_RD     = 4'd9,
    S_MEM_WAIT   = 4'd10,
    S_WB_LW      = 4'd11,
    S_MEM_WR     = 4'd12,
    S_JUMP       = 4'd13,
    S_ILLEGAL    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  state_t state_q, state_d;

  // State register; reset forces FETCH immediately so its outputs show during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opcode/funct only matter in DECODE and ADDR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
              state_d = S_EXEC_R;
            end else begin
              state_d = S_ILLEGAL;
            end
          end
          OP_ADDI:         state_d = S_EXEC_ADDI;
          OP_BEQ, OP_BNE:  state_d = S_EXEC_BR;
          OP_LW, OP_SW:    state_d = S_ADDR;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:     state_d = S_WB_R;
      S_WB_R:       state_d = S_FETCH;
      S_EXEC_ADDI:  state_d = S_WB_I;
      S_WB_I:       state_d = S_FETCH;
      S_EXEC_BR:    state_d = S_FETCH;
      S_ADDR:       state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:     state_d = S_MEM_WAIT;
      S_MEM_WAIT:   state_d = S_WB_LW;
      S_WB_LW:      state_d = S_FETCH;
      S_MEM_WR:     state_d = S_FETCH;
      S_JUMP:       state_d = S_FETCH;
      S_ILLEGAL:    state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:      state_d = S_FETCH;
    endcase
  end

  // Output decode; all Moore except the branch pc_write, which follows zero.
  always_comb begin
    alu_srcA     = 2'b00;
    alu_srcB     = 3'b000;
    alu_op       = 3'b000;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    aluout_write = 1'b0;
    illegal_op   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_srcB = 3'b001;
        alu_op   = 3'b001;
        pc_write = 1'b1;
      end
      S_FETCH_WAIT: begin
        ir_write = 1'b1;
      end
      S_DECODE: begin
        alu_srcB     = 3'b011;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_srcA     = 2'b01;
        aluout_write = 1'b1;
        case (funct)
          FN_ADD:  alu_op = 3'b001;
          FN_SUB:  alu_op = 3'b010;
          FN_AND:  alu_op = 3'b011;
          default: alu_op = 3'b000;
        endcase
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_ADDI, S_ADDR: begin
        alu_srcA     = 2'b01;
        alu_srcB     = 3'b010;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_WB_I: begin
        reg_write = 1'b1;
      end
      S_EXEC_BR: begin
        alu_srcA = 2'b01;
        alu_op   = 3'b010;
        pc_src   = 2'b01;
        pc_write = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WAIT: begin
        iord = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl: one instance halting on illegal
// opcodes and one that pulses illegal_op and returns to FETCH.
module tb_alu_operand_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic [1:0] h_srcA, p_srcA;
  logic [2:0] h_srcB, p_srcB;
  logic [2:0] h_op, p_op;
  logic       h_pcw, p_pcw;
  logic [1:0] h_pcs, p_pcs;
  logic       h_irw, p_irw;
  logic       h_mr, p_mr;
  logic       h_mw, p_mw;
  logic       h_iord, p_iord;
  logic       h_rw, p_rw;
  logic       h_rd, p_rd;
  logic       h_m2r, p_m2r;
  logic       h_aw, p_aw;
  logic       h_ill, p_ill;
  logic [3:0] h_state, p_state;

  logic [19:0] obs_h, obs_p;

  int vectors;
  int miscompares;

  // Field order: srcA, srcB, op, pc_write, pc_src, then
  // ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, aluout_write, illegal_op
  localparam logic [19:0] V_FETCH   = {2'b00, 3'b001, 3'b001, 1'b1, 2'b00, 9'b010000000};
  localparam logic [19:0] V_FWAIT   = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b100000000};
  localparam logic [19:0] V_DECODE  = {2'b00, 3'b011, 3'b001, 1'b0, 2'b00, 9'b000000010};
  localparam logic [19:0] V_ADD     = {2'b01, 3'b000, 3'b001, 1'b0, 2'b00, 9'b000000010};
  localparam logic [19:0] V_SUB     = {2'b01, 3'b000, 3'b010, 1'b0, 2'b00, 9'b000000010};
  localparam logic [19:0] V_AND     = {2'b01, 3'b000, 3'b011, 1'b0, 2'b00, 9'b000000010};
  localparam logic [19:0] V_WBR     = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b000011000};
  localparam logic [19:0] V_IMMADD  = {2'b01, 3'b010, 3'b001, 1'b0, 2'b00, 9'b000000010};
  localparam logic [19:0] V_WBI     = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b000010000};
  localparam logic [19:0] V_BR_TK   = {2'b01, 3'b000, 3'b010, 1'b1, 2'b01, 9'b000000000};
  localparam logic [19:0] V_BR_NT   = {2'b01, 3'b000, 3'b010, 1'b0, 2'b01, 9'b000000000};
  localparam logic [19:0] V_MEMRD   = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b010100000};
  localparam logic [19:0] V_MEMWAIT = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b000100000};
  localparam logic [19:0] V_WBLW    = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b000010100};
  localparam logic [19:0] V_MEMWR   = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b001100000};
  localparam logic [19:0] V_JUMP    = {2'b00, 3'b000, 3'b000, 1'b1, 2'b10, 9'b000000000};
  localparam logic [19:0] V_ILL     = {2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 9'b000000001};

  alu_operand_ctrl #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_srcA(h_srcA), .alu_srcB(h_srcB), .alu_op(h_op), .pc_write(h_pcw),
    .pc_src(h_pcs), .ir_write(h_irw), .mem_read(h_mr), .mem_write(h_mw),
    .iord(h_iord), .reg_write(h_rw), .reg_dst(h_rd), .mem_to_reg(h_m2r),
    .aluout_write(h_aw), .illegal_op(h_ill), .state(h_state)
  );

  alu_operand_ctrl #(.ILLEGAL_HALT(1'b0)) dut_pulse (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_srcA(p_srcA), .alu_srcB(p_srcB), .alu_op(p_op), .pc_write(p_pcw),
    .pc_src(p_pcs), .ir_write(p_irw), .mem_read(p_mr), .mem_write(p_mw),
    .iord(p_iord), .reg_write(p_rw), .reg_dst(p_rd), .mem_to_reg(p_m2r),
    .aluout_write(p_aw), .illegal_op(p_ill), .state(p_state)
  );

  assign obs_h = {h_srcA, h_srcB, h_op, h_pcw, h_pcs, h_irw, h_mr, h_mw, h_iord,
                  h_rw, h_rd, h_m2r, h_aw, h_ill};
  assign obs_p = {p_srcA, p_srcB, p_op, p_pcw, p_pcs, p_irw, p_mr, p_mw, p_iord,
                  p_rw, p_rd, p_m2r, p_aw, p_ill};

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++;
    if (h_state !== 4'd0 || obs_h !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL reset_state: state=%0d obs=%h, expected state=0 obs=%h", h_state, obs_h, V_FETCH);
    end
    step();
    vectors++;
    if (h_state !== 4'd0 || p_state !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: state=%0d/%0d, expected 0/0", h_state, p_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_addr();
    opcode = 6'h23;
    funct  = 6'h00;
    step();
    step();
    step();
    vectors++;
    if (h_state !== 4'd8 || obs_h !== V_IMMADD) begin
      miscompares++;
      $display("[TB] FAIL reach_addr: state=%0d obs=%h, expected state=8 obs=%h", h_state, obs_h, V_IMMADD);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (h_state !== 4'd0 || obs_h !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL async_reset: state=%0d obs=%h, expected state=0 obs=%h", h_state, obs_h, V_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [3];
    logic [19:0] ex [3];
    logic [3:0]  es [5];
    logic [19:0] eo [5];
    fn[0] = 6'h20; ex[0] = V_ADD;
    fn[1] = 6'h22; ex[1] = V_SUB;
    fn[2] = 6'h24; ex[2] = V_AND;
    for (int k = 0; k < 3; k++) begin
      opcode = 6'h00;
      funct  = fn[k];
      es[0] = 4'd0; eo[0] = V_FETCH;
      es[1] = 4'd1; eo[1] = V_FWAIT;
      es[2] = 4'd2; eo[2] = V_DECODE;
      es[3] = 4'd3; eo[3] = ex[k];
      es[4] = 4'd4; eo[4] = V_WBR;
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (h_state !== es[i] || obs_h !== eo[i]) begin
          miscompares++;
          $display("[TB] FAIL rtype_f%h_cyc%0d: state=%0d obs=%h, expected state=%0d obs=%h",
                   fn[k], i, h_state, obs_h, es[i], eo[i]);
        end
        step();
      end
      vectors++;
      if (h_state !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL rtype_f%h_len: state=%0d, expected 0 after 5 cycles", fn[k], h_state);
      end
    end
  endtask

  task automatic test_addi();
    logic [3:0]  es [5];
    logic [19:0] eo [5];
    opcode = 6'h08;
    funct  = 6'h3F;
    es[0] = 4'd0; eo[0] = V_FETCH;
    es[1] = 4'd1; eo[1] = V_FWAIT;
    es[2] = 4'd2; eo[2] = V_DECODE;
    es[3] = 4'd5; eo[3] = V_IMMADD;
    es[4] = 4'd6; eo[4] = V_WBI;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (h_state !== es[i] || obs_h !== eo[i]) begin
        miscompares++;
        $display("[TB] FAIL addi_cyc%0d: state=%0d obs=%h, expected state=%0d obs=%h",
                 i, h_state, obs_h, es[i], eo[i]);
      end
      step();
    end
    vectors++;
    if (h_state !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL addi_len: state=%0d, expected 0", h_state);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op [3];
    logic        zf [3];
    logic [19:0] ev [3];
    logic [19:0] flip [3];
    op[0] = 6'h04; zf[0] = 1'b1; ev[0] = V_BR_TK; flip[0] = V_BR_NT;
    op[1] = 6'h04; zf[1] = 1'b0; ev[1] = V_BR_NT; flip[1] = V_BR_TK;
    op[2] = 6'h05; zf[2] = 1'b0; ev[2] = V_BR_TK; flip[2] = V_BR_NT;
    for (int k = 0; k < 3; k++) begin
      opcode = op[k];
      zero   = zf[k];
      step();
      step();
      vectors++;
      if (h_state !== 4'd2 || obs_h !== V_DECODE) begin
        miscompares++;
        $display("[TB] FAIL br%0d_decode: state=%0d obs=%h, expected state=2 obs=%h", k, h_state, obs_h, V_DECODE);
      end
      step();
      vectors++;
      if (h_state !== 4'd7 || obs_h !== ev[k]) begin
        miscompares++;
        $display("[TB] FAIL br%0d_exec: state=%0d obs=%h, expected state=7 obs=%h", k, h_state, obs_h, ev[k]);
      end
      zero = ~zf[k];
      #1;
      vectors++;
      if (obs_h !== flip[k]) begin
        miscompares++;
        $display("[TB] FAIL br%0d_mealy: obs=%h, expected obs=%h", k, obs_h, flip[k]);
      end
      zero = zf[k];
      step();
      vectors++;
      if (h_state !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL br%0d_len: state=%0d, expected 0 after 4 cycles", k, h_state);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_load_store();
    logic [3:0]  es [7];
    logic [19:0] eo [7];
    opcode = 6'h23;
    es[0] = 4'd0;  eo[0] = V_FETCH;
    es[1] = 4'd1;  eo[1] = V_FWAIT;
    es[2] = 4'd2;  eo[2] = V_DECODE;
    es[3] = 4'd8;  eo[3] = V_IMMADD;
    es[4] = 4'd9;  eo[4] = V_MEMRD;
    es[5] = 4'd10; eo[5] = V_MEMWAIT;
    es[6] = 4'd11; eo[6] = V_WBLW;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (h_state !== es[i] || obs_h !== eo[i]) begin
        miscompares++;
        $display("[TB] FAIL lw_cyc%0d: state=%0d obs=%h, expected state=%0d obs=%h",
                 i, h_state, obs_h, es[i], eo[i]);
      end
      step();
    end
    vectors++;
    if (h_state !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL lw_len: state=%0d, expected 0 after 7 cycles", h_state);
    end
    opcode = 6'h2B;
    es[4] = 4'd12; eo[4] = V_MEMWR;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (h_state !== es[i] || obs_h !== eo[i]) begin
        miscompares++;
        $display("[TB] FAIL sw_cyc%0d: state=%0d obs=%h, expected state=%0d obs=%h",
                 i, h_state, obs_h, es[i], eo[i]);
      end
      step();
    end
    vectors++;
    if (h_state !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL sw_len: state=%0d, expected 0 after 5 cycles", h_state);
    end
  endtask

  task automatic test_jump();
    opcode = 6'h02;
    step();
    step();
    vectors++;
    if (h_state !== 4'd2 || obs_h !== V_DECODE) begin
      miscompares++;
      $display("[TB] FAIL j_decode: state=%0d obs=%h, expected state=2 obs=%h", h_state, obs_h, V_DECODE);
    end
    step();
    vectors++;
    if (h_state !== 4'd13 || obs_h !== V_JUMP) begin
      miscompares++;
      $display("[TB] FAIL j_exec: state=%0d obs=%h, expected state=13 obs=%h", h_state, obs_h, V_JUMP);
    end
    step();
    vectors++;
    if (h_state !== 4'd0 || obs_h !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL j_len: state=%0d obs=%h, expected state=0 obs=%h", h_state, obs_h, V_FETCH);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op_in, input logic [5:0] fn_in);
    opcode = op_in;
    funct  = fn_in;
    step();
    step();
    step();
    vectors++;
    if (h_state !== 4'd14 || obs_h !== V_ILL || p_state !== 4'd14 || obs_p !== V_ILL) begin
      miscompares++;
      $display("[TB] FAIL ill_%h_%h_enter: state=%0d/%0d obs=%h/%h, expected 14/14 obs=%h",
               op_in, fn_in, h_state, p_state, obs_h, obs_p, V_ILL);
    end
    step();
    vectors++;
    if (p_state !== 4'd0 || obs_p !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL ill_%h_%h_pulse: state=%0d obs=%h, expected state=0 obs=%h",
               op_in, fn_in, p_state, obs_p, V_FETCH);
    end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (h_state !== 4'd14 || obs_h !== V_ILL) begin
        miscompares++;
        $display("[TB] FAIL ill_%h_%h_hold%0d: state=%0d obs=%h, expected state=14 obs=%h",
                 op_in, fn_in, i, h_state, obs_h, V_ILL);
      end
      step();
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (h_state !== 4'd0 || obs_h !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL ill_%h_%h_release: state=%0d obs=%h, expected state=0 obs=%h",
               op_in, fn_in, h_state, obs_h, V_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    opcode      = 6'h00;
    funct       = 6'h20;
    zero        = 1'b0;
    $display("[TB] starting alu_operand_ctrl directed run");
    test_reset();
    test_reset_mid_addr();
    test_rtype();
    test_addi();
    test_branch();
    test_load_store();
    test_jump();
    test_illegal(6'h3F, 6'h20);
    test_illegal(6'h00, 6'h25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
